trap_sequencer: RTL and testbench

//  Multi-cycle controller that takes traps and MRET retiring from writeback and sequences the machine CSR updates over the single CSR write port.

---
 rtl/trap_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: serialises the mepc, mcause, mtval and mstatus writes, then redirects fetch.
// Define TRAP_VECTORED_EN to send interrupts to BASE + 4*cause when mtvec mode is vectored.
module trap_sequencer #(
    parameter int          XLEN      = 64,
    parameter logic [11:0] A_MSTATUS = 12'h300,
    parameter logic [11:0] A_MEPC    = 12'h341,
    parameter logic [11:0] A_MCAUSE  = 12'h342,
    parameter logic [11:0] A_MTVAL   = 12'h343
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WB_V,
    input  logic [XLEN-1:0] WB_PC,
    input  logic [XLEN-1:0] WB_NPC,
    input  logic [31:0]     WB_IR,
    input  logic            WB_MRET,
    input  logic [7:0]      EXC_VEC,
    input  logic [XLEN-1:0] FAULT_ADDR,
    input  logic            TIMER,
    input  logic            EXTERNAL,
    input  logic [XLEN-1:0] MSTATUS_IN,
    input  logic [XLEN-1:0] MTVEC_IN,
    input  logic [XLEN-1:0] MEPC_IN,
    output logic            CSR_WE,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            FLUSH,
    output logic            STALL,
    output logic            REDIRECT_V,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic            PRIVILEGE
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR, M_STATUS
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            mret_q, mret_d;
    logic            priv_q, priv_d;

    logic            take, is_irq;
    logic [XLEN-1:0] trig_cause, trig_tval;
    logic [XLEN-1:0] trap_base, trap_target, ms;

    // Trigger priority: interrupts (gated by MIE) first, then exceptions.
    always_comb begin
        take       = 1'b1;
        is_irq     = 1'b0;
        trig_cause = '0;
        trig_tval  = '0;
        if (MSTATUS_IN[3] && EXTERNAL) begin
            is_irq = 1'b1;
            trig_cause = XLEN'(11);
            trig_cause[XLEN-1] = 1'b1;
        end else if (MSTATUS_IN[3] && TIMER) begin
            is_irq = 1'b1;
            trig_cause = XLEN'(7);
            trig_cause[XLEN-1] = 1'b1;
        end else if (EXC_VEC[0]) begin
            trig_cause = XLEN'(1);
            trig_tval  = FAULT_ADDR;
        end else if (EXC_VEC[1]) begin
            trig_cause = XLEN'(2);
            trig_tval  = XLEN'(WB_IR);
        end else if (EXC_VEC[2]) begin
            trig_cause = XLEN'(0);
            trig_tval  = FAULT_ADDR;
        end else if (EXC_VEC[3]) begin
            trig_cause = priv_q ? XLEN'(11) : XLEN'(8);
        end else if (EXC_VEC[4]) begin
            trig_cause = XLEN'(6);
            trig_tval  = FAULT_ADDR;
        end else if (EXC_VEC[5]) begin
            trig_cause = XLEN'(4);
            trig_tval  = FAULT_ADDR;
        end else if (EXC_VEC[6]) begin
            trig_cause = XLEN'(7);
            trig_tval  = FAULT_ADDR;
        end else if (EXC_VEC[7]) begin
            trig_cause = XLEN'(5);
            trig_tval  = FAULT_ADDR;
        end else begin
            take = 1'b0;
        end
    end

    always_comb begin
        trap_base   = MTVEC_IN & ~XLEN'(3);
        trap_target = trap_base;
`ifdef TRAP_VECTORED_EN
        if (MTVEC_IN[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_target = trap_base + XLEN'({cause_q[5:0], 2'b00});
`endif
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        mret_d      = mret_q;
        priv_d      = priv_q;
        CSR_WE      = 1'b0;
        CSR_ADDR    = '0;
        CSR_WDATA   = '0;
        FLUSH       = 1'b0;
        STALL       = 1'b1;
        REDIRECT_V  = 1'b0;
        REDIRECT_PC = '0;
        ms          = MSTATUS_IN;
        case (state_q)
            IDLE: begin
                STALL = 1'b0;
                if (WB_V && take) begin
                    cause_d = trig_cause;
                    epc_d   = is_irq ? WB_NPC : WB_PC;
                    tval_d  = trig_tval;
                    mret_d  = 1'b0;
                    state_d = W_EPC;
                end else if (WB_V && WB_MRET) begin
                    epc_d   = MEPC_IN;
                    mret_d  = 1'b1;
                    state_d = M_STATUS;
                end
            end
            W_EPC: begin
                FLUSH     = 1'b1;
                CSR_WE    = 1'b1;
                CSR_ADDR  = A_MEPC;
                CSR_WDATA = epc_q;
                state_d   = W_CAUSE;
            end
            W_CAUSE: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = A_MCAUSE;
                CSR_WDATA = cause_q;
                state_d   = W_TVAL;
            end
            W_TVAL: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = A_MTVAL;
                CSR_WDATA = tval_q;
                state_d   = W_STATUS;
            end
            W_STATUS: begin
                ms[7]     = MSTATUS_IN[3];
                ms[3]     = 1'b0;
                ms[12:11] = {2{priv_q}};
                CSR_WE    = 1'b1;
                CSR_ADDR  = A_MSTATUS;
                CSR_WDATA = ms;
                priv_d    = 1'b1;
                state_d   = REDIR;
            end
            M_STATUS: begin
                ms[3]     = MSTATUS_IN[7];
                ms[7]     = 1'b1;
                ms[12:11] = 2'b00;
                FLUSH     = 1'b1;
                CSR_WE    = 1'b1;
                CSR_ADDR  = A_MSTATUS;
                CSR_WDATA = ms;
                priv_d    = (MSTATUS_IN[12:11] == 2'b11);
                state_d   = REDIR;
            end
            REDIR: begin
                REDIRECT_V  = 1'b1;
                REDIRECT_PC = mret_q ? epc_q : trap_target;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            mret_q  <= 1'b0;
            priv_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            mret_q  <= mret_d;
            priv_q  <= priv_d;
        end
    end

    assign PRIVILEGE = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects are queued with their cycle.
module tb_trap_sequencer;
    localparam int XLEN = 64;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            WB_V = 1'b0;
    logic [XLEN-1:0] WB_PC = '0;
    logic [XLEN-1:0] WB_NPC = '0;
    logic [31:0]     WB_IR = '0;
    logic            WB_MRET = 1'b0;
    logic [7:0]      EXC_VEC = '0;
    logic [XLEN-1:0] FAULT_ADDR = '0;
    logic            TIMER = 1'b0;
    logic            EXTERNAL = 1'b0;
    logic [XLEN-1:0] MSTATUS_IN = '0;
    logic [XLEN-1:0] MTVEC_IN = 64'h8000;
    logic [XLEN-1:0] MEPC_IN = '0;
    logic            CSR_WE;
    logic [11:0]     CSR_ADDR;
    logic [XLEN-1:0] CSR_WDATA;
    logic            FLUSH;
    logic            STALL;
    logic            REDIRECT_V;
    logic [XLEN-1:0] REDIRECT_PC;
    logic            PRIVILEGE;

    trap_sequencer #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .WB_NPC(WB_NPC),
        .WB_IR(WB_IR), .WB_MRET(WB_MRET), .EXC_VEC(EXC_VEC), .FAULT_ADDR(FAULT_ADDR),
        .TIMER(TIMER), .EXTERNAL(EXTERNAL), .MSTATUS_IN(MSTATUS_IN), .MTVEC_IN(MTVEC_IN),
        .MEPC_IN(MEPC_IN), .CSR_WE(CSR_WE), .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA),
        .FLUSH(FLUSH), .STALL(STALL), .REDIRECT_V(REDIRECT_V), .REDIRECT_PC(REDIRECT_PC),
        .PRIVILEGE(PRIVILEGE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned cyc;
        bit          redir;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int unsigned c, input bit r, input logic [11:0] a, input logic [63:0] d);
        exp_t e;
        e.cyc = c; e.redir = r; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic push_trap(input int unsigned cap, input logic [63:0] epc, input logic [63:0] cause,
                             input logic [63:0] tval, input logic [63:0] mst, input logic [63:0] tgt);
        push(cap,     1'b0, 12'h341, epc);
        push(cap + 1, 1'b0, 12'h342, cause);
        push(cap + 2, 1'b0, 12'h343, tval);
        push(cap + 3, 1'b0, 12'h300, mst);
        push(cap + 4, 1'b1, 12'h000, tgt);
    endtask

    // Monitor: every CSR write or redirect must match the head of the queue, including its cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (CSR_WE || REDIRECT_V) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: we=%b addr=%h data=%h redir=%b pc=%h required none (cycle %0d)",
                         CSR_WE, CSR_ADDR, CSR_WDATA, REDIRECT_V, REDIRECT_PC, cyc);
            end else begin
                e = q.pop_front();
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                if (e.redir) begin
                    check("redirect_v", 64'(REDIRECT_V), 64'd1);
                    check("redirect_pc", REDIRECT_PC, e.data);
                    check("csr_we_in_redir", 64'(CSR_WE), 64'd0);
                end else begin
                    check("csr_addr", 64'(CSR_ADDR), 64'(e.addr));
                    check("csr_wdata", CSR_WDATA, e.data);
                    check("redirect_during_write", 64'(REDIRECT_V), 64'd0);
                end
            end
        end
    end

    task automatic idle_inputs();
        WB_V = 1'b0; WB_MRET = 1'b0; EXC_VEC = '0; TIMER = 1'b0; EXTERNAL = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (STALL && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (STALL) begin
            miscompares++;
            $display("FAIL idle_timeout: STALL still %b after %0d cycles, required 0", STALL, n);
        end
        check("queue_drained", 64'(q.size()), 64'd0);
    endtask

    // Inputs must already be set with WB_V=1; hold keeps a different trap on the inputs while busy.
    task automatic run_seq(input bit hold);
        @(posedge CLK); #1;
        check("flush_first", 64'(FLUSH), 64'd1);
        check("stall_busy", 64'(STALL), 64'd1);
        if (hold) begin
            EXC_VEC = 8'h02; WB_MRET = 1'b0; WB_PC = 64'hBAD0; WB_IR = 32'h1234_5678;
        end else begin
            idle_inputs();
        end
        @(posedge CLK); #1;
        check("flush_second", 64'(FLUSH), 64'd0);
        check("stall_second", 64'(STALL), 64'd1);
        if (hold) begin
            @(posedge CLK); @(posedge CLK); #1;
            idle_inputs();
        end
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csr_we"}, 64'(CSR_WE), 64'd0);
        check({tag, "_csr_addr"}, 64'(CSR_ADDR), 64'd0);
        check({tag, "_csr_wdata"}, CSR_WDATA, 64'd0);
        check({tag, "_flush"}, 64'(FLUSH), 64'd0);
        check({tag, "_stall"}, 64'(STALL), 64'd0);
        check({tag, "_redirect_v"}, 64'(REDIRECT_V), 64'd0);
        check({tag, "_redirect_pc"}, REDIRECT_PC, 64'd0);
        check({tag, "_privilege"}, 64'(PRIVILEGE), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] vec_tgt;
        repeat (2) @(posedge CLK);
        #1 check_reset_outputs("reset");
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Illegal instruction from M-mode
        WB_PC = 64'h1000; WB_NPC = 64'h1004; WB_IR = 32'hFFFF_FFFF; EXC_VEC = 8'h02;
        MSTATUS_IN = 64'h8; MTVEC_IN = 64'h8000; FAULT_ADDR = 64'h7777; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h1000, 64'd2, 64'hFFFF_FFFF, 64'h1880, 64'h8000);
        run_seq(1'b0);
        check("priv_after_ii", 64'(PRIVILEGE), 64'd1);

        // MRET back to U-mode
        MSTATUS_IN = 64'h80; MEPC_IN = 64'h1004; WB_MRET = 1'b1; WB_V = 1'b1;
        push(cyc + 1, 1'b0, 12'h300, 64'h88);
        push(cyc + 2, 1'b1, 12'h000, 64'h1004);
        run_seq(1'b0);
        check("priv_after_mret", 64'(PRIVILEGE), 64'd0);

        // ECALL from U-mode
        MSTATUS_IN = 64'h88; WB_PC = 64'h2000; WB_NPC = 64'h2004; EXC_VEC = 8'h08; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h2000, 64'd8, 64'd0, 64'h80, 64'h8000);
        run_seq(1'b0);
        check("priv_after_ecall", 64'(PRIVILEGE), 64'd1);

        // External + timer + LAM with MIE=1: external interrupt wins, mepc = next PC
        MSTATUS_IN = 64'h8; WB_PC = 64'h3000; WB_NPC = 64'h3004; FAULT_ADDR = 64'hDEAD0;
        EXC_VEC = 8'h20; TIMER = 1'b1; EXTERNAL = 1'b1; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h3004, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 64'h8000);
        run_seq(1'b0);

        // Same with MIE=0: LAM taken
        MSTATUS_IN = 64'h0; EXC_VEC = 8'h20; TIMER = 1'b1; EXTERNAL = 1'b1; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h3000, 64'd4, 64'hDEAD0, 64'h1800, 64'h8000);
        run_seq(1'b0);

        // Timer interrupt with vectored mtvec
`ifdef TRAP_VECTORED_EN
        vec_tgt = 64'h801C;
`else
        vec_tgt = 64'h8000;
`endif
        MTVEC_IN = 64'h8001; MSTATUS_IN = 64'h8; WB_PC = 64'h4000; WB_NPC = 64'h4004;
        TIMER = 1'b1; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h4004, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, vec_tgt);
        run_seq(1'b0);
        MTVEC_IN = 64'h8000;

        // MRET + SAF together: trap wins; a second trap held while stalled is ignored
        MSTATUS_IN = 64'h0; WB_PC = 64'h5000; WB_NPC = 64'h5004; FAULT_ADDR = 64'h5555;
        EXC_VEC = 8'h40; WB_MRET = 1'b1; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h5000, 64'd7, 64'h5555, 64'h1800, 64'h8000);
        run_seq(1'b1);

        // Drop to U-mode, then reset during W_CAUSE
        MSTATUS_IN = 64'h80; MEPC_IN = 64'h1004; WB_MRET = 1'b1; WB_V = 1'b1;
        push(cyc + 1, 1'b0, 12'h300, 64'h88);
        push(cyc + 2, 1'b1, 12'h000, 64'h1004);
        run_seq(1'b0);
        check("priv_before_reset", 64'(PRIVILEGE), 64'd0);

        MSTATUS_IN = 64'h0; WB_PC = 64'h6000; WB_NPC = 64'h6004; WB_IR = 32'hFFFF_FFFF;
        EXC_VEC = 8'h02; WB_V = 1'b1;
        push(cyc + 1, 1'b0, 12'h341, 64'h6000);
        @(posedge CLK); #1;
        idle_inputs();
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        check("queue_after_reset", 64'(q.size()), 64'd0);
        @(posedge CLK); #1;

        // New trap after reset release (SAM, privilege back to M)
        MSTATUS_IN = 64'h8; WB_PC = 64'h7000; WB_NPC = 64'h7004; FAULT_ADDR = 64'h7008;
        EXC_VEC = 8'h10; WB_V = 1'b1;
        push_trap(cyc + 1, 64'h7000, 64'd6, 64'h7008, 64'h1880, 64'h8000);
        run_seq(1'b0);

        repeat (3) @(posedge CLK);
        #1 check("final_queue", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
